// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline: ALU opcodes, forward selects
// and default datapath widths.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_XOR  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/alu32.sv
// Combinational ALU for the execute stage; add/sub wrap,
// set-less-than results are zero-extended to the datapath width.
module alu32
    import mips_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_t      op,
    output logic [W-1:0] result,
    output logic         zero
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {{(W-1){1'b0}}, lt_s};
            ALU_NOR:  result = ~(a | b);
            ALU_XOR:  result = a ^ b;
            ALU_SLTU: result = {{(W-1){1'b0}}, lt_u};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with MEM/WB operand forwarding and the EX/MEM register.
// Forwarding is built only when EX_MEM_STAGE_FWD_EN is defined.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] exDataIn1,
    input  logic [DATA_W-1:0] exDataIn2,
    input  logic [REG_AW-1:0] exRsIn,
    input  logic [REG_AW-1:0] exRtIn,
    input  logic [REG_AW-1:0] exRdIn,
    input  logic [15:0]       exOffsetIn,
    input  logic [2:0]        exAluOpIn,
    input  logic              exRegWriteIn,
    input  logic              exRegDstIn,
    input  logic              exMemWriteIn,
    input  logic              exMemReadIn,
    input  logic              exAluSelIn,
    input  logic              exMemToRegIn,
    input  logic              memFwdRegWrite,
    input  logic [REG_AW-1:0] memFwdAdr,
    input  logic [DATA_W-1:0] memFwdData,
    input  logic              wbFwdRegWrite,
    input  logic [REG_AW-1:0] wbFwdAdr,
    input  logic [DATA_W-1:0] wbFwdData,
    output logic [DATA_W-1:0] memAluResult,
    output logic [DATA_W-1:0] memStoreData,
    output logic [REG_AW-1:0] memWriteAdr,
    output logic              memRegWrite,
    output logic              memMemWrite,
    output logic              memMemRead,
    output logic              memMemToReg,
    output logic              memZero,
    output logic [1:0]        fwdSelA,
    output logic [1:0]        fwdSelB
);

    fwd_sel_t          sel_a;
    fwd_sel_t          sel_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic              alu_z;
    logic [REG_AW-1:0] dst;
    logic              reg_wr;

`ifdef EX_MEM_STAGE_FWD_EN
    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;

    // Register 0 is hard-wired, so a write to it is never a hazard.
    assign mem_hit_a = memFwdRegWrite && (memFwdAdr != '0)
                       && (memFwdAdr == exRsIn);
    assign mem_hit_b = memFwdRegWrite && (memFwdAdr != '0)
                       && (memFwdAdr == exRtIn);
    assign wb_hit_a  = wbFwdRegWrite && (wbFwdAdr != '0)
                       && (wbFwdAdr == exRsIn);
    assign wb_hit_b  = wbFwdRegWrite && (wbFwdAdr != '0)
                       && (wbFwdAdr == exRtIn);

    always_comb begin
        sel_a = FWD_NONE;
        priority case (1'b1)
            mem_hit_a: sel_a = FWD_MEM;
            wb_hit_a:  sel_a = FWD_WB;
            default:   sel_a = FWD_NONE;
        endcase
    end

    always_comb begin
        sel_b = FWD_NONE;
        priority case (1'b1)
            mem_hit_b: sel_b = FWD_MEM;
            wb_hit_b:  sel_b = FWD_WB;
            default:   sel_b = FWD_NONE;
        endcase
    end

    always_comb begin
        op_a = exDataIn1;
        unique case (sel_a)
            FWD_MEM: op_a = memFwdData;
            FWD_WB:  op_a = wbFwdData;
            default: op_a = exDataIn1;
        endcase
    end

    always_comb begin
        fwd_b = exDataIn2;
        unique case (sel_b)
            FWD_MEM: fwd_b = memFwdData;
            FWD_WB:  fwd_b = wbFwdData;
            default: fwd_b = exDataIn2;
        endcase
    end
`else
    logic unused_fwd;

    assign sel_a = FWD_NONE;
    assign sel_b = FWD_NONE;
    assign op_a  = exDataIn1;
    assign fwd_b = exDataIn2;
    assign unused_fwd = ^{memFwdRegWrite, memFwdAdr, memFwdData,
                          wbFwdRegWrite, wbFwdAdr, wbFwdData, exRsIn};
`endif

    assign fwdSelA = sel_a;
    assign fwdSelB = sel_b;

    assign imm   = {{(DATA_W-16){exOffsetIn[15]}}, exOffsetIn};
    assign alu_b = exAluSelIn ? imm : fwd_b;

    alu32 #(
        .W(DATA_W)
    ) u_alu (
        .a     (op_a),
        .b     (alu_b),
        .op    (alu_op_t'(exAluOpIn)),
        .result(alu_y),
        .zero  (alu_z)
    );

    assign dst    = exRegDstIn ? exRdIn : exRtIn;
    assign reg_wr = exRegWriteIn && (dst != '0);

    // Flush outranks stall so a squashed slot never survives a hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memAluResult <= '0;
            memStoreData <= '0;
            memWriteAdr  <= '0;
            memRegWrite  <= 1'b0;
            memMemWrite  <= 1'b0;
            memMemRead   <= 1'b0;
            memMemToReg  <= 1'b0;
            memZero      <= 1'b0;
        end else if (flush) begin
            memAluResult <= '0;
            memStoreData <= '0;
            memWriteAdr  <= '0;
            memRegWrite  <= 1'b0;
            memMemWrite  <= 1'b0;
            memMemRead   <= 1'b0;
            memMemToReg  <= 1'b0;
            memZero      <= 1'b0;
        end else if (!stall) begin
            memAluResult <= alu_y;
            memStoreData <= fwd_b;
            memWriteAdr  <= dst;
            memRegWrite  <= reg_wr;
            memMemWrite  <= exMemWriteIn;
            memMemRead   <= exMemReadIn;
            memMemToReg  <= exMemToRegIn;
            memZero      <= alu_z;
        end
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage of the 5-stage MIPS pipeline plus the EX/MEM pipeline register. Consumes operands, register addresses, immediate and control bits latched by the ID/EX register. Forwards from the MEM and WB stages, computes the ALU result, selects the destination register, and registers everything for the MEM stage.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold the EX/MEM register
- flush  in  1  load a bubble into the EX/MEM register
- exDataIn1, exDataIn2  in  DATA_W  register-file operands from ID/EX
- exRsIn, exRtIn, exRdIn  in  REG_AW  register addresses from ID/EX
- exOffsetIn  in  16  immediate field
- exAluOpIn  in  3  ALU operation
- exRegWriteIn, exRegDstIn, exMemWriteIn, exMemReadIn, exAluSelIn, exMemToRegIn  in  1 each  control bits
- memFwdRegWrite  in  1  MEM-stage instruction writes a register
- memFwdAdr  in  REG_AW  MEM-stage destination
- memFwdData  in  DATA_W  MEM-stage ALU result
- wbFwdRegWrite  in  1  WB-stage instruction writes a register
- wbFwdAdr  in  REG_AW  WB-stage destination
- wbFwdData  in  DATA_W  WB write-back data
- memAluResult  out  DATA_W  registered ALU result
- memStoreData  out  DATA_W  registered forwarded B operand
- memWriteAdr  out  REG_AW  registered destination
- memRegWrite, memMemWrite, memMemRead, memMemToReg  out  1 each  registered control bits
- memZero  out  1  registered (ALU result == 0)
- fwdSelA, fwdSelB  out  2  combinational forward selects (0 = ID/EX, 1 = MEM, 2 = WB)

## Operation
- Forwarding, operand A:
  - If memFwdRegWrite, memFwdAdr != 0 and memFwdAdr == exRsIn → select memFwdData.
  - Else if wbFwdRegWrite, wbFwdAdr != 0 and wbFwdAdr == exRsIn → select wbFwdData.
  - Else select exDataIn1.
  - MEM has priority over WB.
- Operand B uses the same rules against exRtIn and exDataIn2. The result is fwdB.
- Immediate = sign-extended exOffsetIn.
- ALU second input = immediate when exAluSelIn = 1, else fwdB.
- memStoreData always takes fwdB, never the immediate.
- ALU ops:
  - 000 add, 001 sub, 010 and, 011 or, 100 slt (signed), 101 nor, 110 xor, 111 sltu.
  - add and sub wrap modulo 2^DATA_W; overflow is ignored.
  - slt and sltu produce 0 or 1 zero-extended.
- Destination = exRdIn when exRegDstIn = 1, else exRtIn.
- Register 0 as destination: memRegWrite is forced to 0.

## Timing
- EX/MEM register latency: 1 cycle. Inputs sampled at the rising edge appear on the mem* outputs after that edge.
- Reset (rst low, asynchronous): every registered output goes to 0 immediately and holds while rst is low. The first capture is on the first rising edge after rst goes high.
- stall = 1, flush = 0: register holds all values.
- flush = 1: on the next edge, memRegWrite, memMemWrite, memMemRead, memMemToReg, memAluResult, memStoreData, memWriteAdr and memZero all load 0. Flush wins over stall.
- Forwarding is combinational within the cycle. fwdSelA and fwdSelB settle in the same cycle as their inputs.
- Both forward sources matching with address 0: no forwarding (select 0).
- Reset deasserted mid-stream: no state is retained, and the pipeline restarts from bubbles.

## Configuration
- EX_MEM_STAGE_FWD_EN defined:
  - Forwarding logic is present as described.
- EX_MEM_STAGE_FWD_EN undefined:
  - Operands always come from exDataIn1 and exDataIn2.
  - fwdSelA and fwdSelB are tied to 0.
  - The memFwd* and wbFwd* inputs are unused.
  - The hazard unit must stall instead.

## Structure
- Shared package mips_pkg holds:
  - DATA_W and REG_AW defaults.
  - typedef alu_op_t: 3-bit enum with the eight operations above.
  - typedef fwd_sel_t: 2-bit, values FWD_NONE, FWD_MEM, FWD_WB.
- One sub-module, alu32: combinational, takes a, b and alu_op_t, produces result and zero.

## Test plan
- Reset:
  - Stimulus: drive rst low mid-cycle after nonzero outputs.
  - Required: all mem* outputs drop to 0 before the next clock edge.
- add via immediate:
  - Stimulus: exDataIn1=5, exOffsetIn=16'hFFFF, exAluSelIn=1, aluOp=000, exRegDstIn=0, exRtIn=7, exRegWriteIn=1.
  - Required, next cycle: memAluResult=4, memWriteAdr=7, memRegWrite=1.
- MEM priority over WB:
  - Stimulus: exRsIn=3, memFwdAdr=3 with memFwdData=100, wbFwdAdr=3 with wbFwdData=200, both regWrite=1, aluOp=000, B=1.
  - Required: fwdSelA=1, memAluResult=101.
- Register 0 protection:
  - Stimulus: memFwdAdr=0, memFwdRegWrite=1, exRsIn=0.
  - Required: fwdSelA=0. A destination of 0 with exRegWriteIn=1 gives memRegWrite=0.
- Stall and flush:
  - Stimulus: hold stall=1 for 2 cycles with changing inputs, then assert stall=1 and flush=1 together.
  - Required: outputs hold their previous values during the stall, then all go to 0.
- slt vs sltu:
  - Stimulus: A=32'hFFFFFFFF, B=1.
  - Required: slt gives 1, sltu gives 0, and memZero=1 for the sltu case.
